// File: rtl/kred_multi_pipe_if.sv
// kred_multi_pipe_if: valid/ready sample bus around the multi-round K-RED reducer.
//   in_valid/in_ready : input handshake
//   in_c, in_qh, in_tag : product to reduce, its qH, and a sideband tag
//   out_valid/out_ready : output handshake
//   out_t, out_tag : reduced result and the tag that travelled with it
interface kred_multi_pipe_if #(
   parameter int unsigned LOGC  = 24,
   parameter int unsigned LOGQH = 4,
   parameter int unsigned TAGW  = 4,
   parameter int unsigned LOGT  = 12
);
   logic             in_valid;
   logic             in_ready;
   logic [LOGC-1:0]  in_c;
   logic [LOGQH-1:0] in_qh;
   logic [TAGW-1:0]  in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [LOGT-1:0]  out_t;
   logic [TAGW-1:0]  out_tag;

   modport master (output in_valid, in_c, in_qh, in_tag, out_ready,
                   input  in_ready, out_valid, out_t, out_tag);
   modport slave  (input  in_valid, in_c, in_qh, in_tag, out_ready,
                   output in_ready, out_valid, out_t, out_tag);
endinterface

// File: rtl/kred_multi_pipe.sv
// kred_multi_pipe: NRED pipelined K-RED rounds (result == qH^NRED * C mod q,
// q = qH*2^M + 1) with optional final correction into [0,q).
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of every stage valid bit
//   bus        : slave side of kred_multi_pipe_if (in_*/out_* handshakes)
//   busy       : some stage holds a valid sample
module kred_multi_pipe #(
   parameter int unsigned LOGQ    = 12,
   parameter int unsigned LOGQH   = 4,
   parameter int unsigned NRED    = 2,
   parameter int unsigned CORRECT = 1,
   parameter int unsigned TAGW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   kred_multi_pipe_if.slave bus,
   output logic             busy
);
   localparam int unsigned M    = LOGQ - LOGQH;
   localparam int unsigned LOGC = 2 * LOGQ;
   localparam int unsigned LOGT = (CORRECT != 0) ? LOGQ : LOGQ + 2;
   localparam int unsigned LAT  = NRED + CORRECT;
   // Signed working width: comfortably holds C < q^2 and every round result.
   localparam int unsigned W    = LOGC + 2;

   // Parameter legality
   if (2 * LOGQH > LOGQ) begin : g_bad_logqh
      $error("kred_multi_pipe: LOGQH must not exceed LOGQ-LOGQH");
   end
   if (NRED < 1 || NRED > 4) begin : g_bad_nred
      $error("kred_multi_pipe: NRED must be in 1..4");
   end
   if (CORRECT > 1 || (CORRECT == 1 && NRED < 2)) begin : g_bad_correct
      $error("kred_multi_pipe: CORRECT must be 0/1 and CORRECT=1 needs NRED>=2");
   end

   logic           out_vld;
   logic           en;
   logic [LAT-1:0] vld_all;

   // Whole pipe advances together; flush blocks acceptance and wins over stall.
   assign en            = !out_vld || bus.out_ready;
   assign bus.in_ready  = en && !flush;
   assign bus.out_valid = out_vld;
   assign busy          = |vld_all;

   // One K-RED round per stage: T' = qH*(T mod 2^M) - (T >>> M)
   for (genvar s = 0; s < NRED; s++) begin : g_round
      logic signed [W-1:0] src;
      logic [LOGQH-1:0]    qh;
      logic [TAGW-1:0]     tag;
      logic                vld;
      logic signed [W-1:0] prod;
      logic signed [W-1:0] t_nxt;
      logic                vld_q;
      logic signed [W-1:0] t_q;
      logic [LOGQH-1:0]    qh_q;
      logic [TAGW-1:0]     tag_q;

      if (s == 0) begin : g_first
         assign src = $signed(W'(bus.in_c));
         assign qh  = bus.in_qh;
         assign tag = bus.in_tag;
         assign vld = bus.in_valid;
      end else begin : g_next
         assign src = g_round[s-1].t_q;
         assign qh  = g_round[s-1].qh_q;
         assign tag = g_round[s-1].tag_q;
         assign vld = g_round[s-1].vld_q;
      end

      assign prod  = $signed(W'(qh)) * $signed(W'(src[M-1:0]));
      assign t_nxt = prod - (src >>> M);
      assign vld_all[s] = vld_q;

      // Stage register; qH and tag ride along with the data
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            t_q   <= '0;
            qh_q  <= '0;
            tag_q <= '0;
         end else if (flush) begin
            vld_q <= 1'b0;
         end else if (en) begin
            vld_q <= vld;
            t_q   <= t_nxt;
            qh_q  <= qh;
            tag_q <= tag;
         end
      end
   end

   if (CORRECT != 0) begin : g_corr
      logic signed [W-1:0] t_last;
      logic signed [W-1:0] q;
      logic                vld_q;
      logic [LOGT-1:0]     t_q;
      logic [TAGW-1:0]     tag_q;

      assign t_last = g_round[NRED-1].t_q;
      assign q      = $signed((W'(g_round[NRED-1].qh_q) << M) + W'(1));
      assign vld_all[LAT-1] = vld_q;

      // T_NRED lies in (-q, 2q): one add or subtract of q lands it in [0,q)
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            t_q   <= '0;
            tag_q <= '0;
         end else if (flush) begin
            vld_q <= 1'b0;
         end else if (en) begin
            vld_q <= g_round[NRED-1].vld_q;
            tag_q <= g_round[NRED-1].tag_q;
            if (t_last[W-1])
               t_q <= LOGT'(t_last + q);
            else if (t_last >= q)
               t_q <= LOGT'(t_last - q);
            else
               t_q <= LOGT'(t_last);
         end
      end

      assign out_vld     = vld_q;
      assign bus.out_t   = t_q;
      assign bus.out_tag = tag_q;
   end else begin : g_raw
      logic unused_bits;

      // Raw signed result straight from the last round register
      assign out_vld     = g_round[NRED-1].vld_q;
      assign bus.out_t   = LOGT'(g_round[NRED-1].t_q);
      assign bus.out_tag = g_round[NRED-1].tag_q;
      assign unused_bits = ^{g_round[NRED-1].qh_q, g_round[NRED-1].t_q[W-1:LOGT]};
   end
endmodule

// File: tb/tb_kred_multi_pipe.sv
// tb_kred_multi_pipe: scoreboard + vector-table bench for kred_multi_pipe.
//   dut_a : LOGQ=12 LOGQH=4 NRED=2 CORRECT=1
//   dut_b : LOGQ=12 LOGQH=4 NRED=1 CORRECT=0
module tb_kred_multi_pipe;
   localparam int unsigned LOGC = 24;

   typedef struct {
      logic [23:0] c;
      logic [3:0]  qh;
      logic [3:0]  tag;
      logic [11:0] exp;
   } vec_t;

   typedef struct {
      logic [23:0] c;
      logic [3:0]  qh;
      logic [13:0] exp;
   } vecb_t;

   typedef struct {
      logic [11:0] t;
      logic [3:0]  tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush_a = 1'b0;
   logic flush_b = 1'b0;
   logic busy_a;
   logic busy_b;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   exp_t sb[$];
   int out_cyc[$];
   vec_t vt[16];
   vecb_t vb[5];
   logic [11:0] snap_t;
   logic [3:0] snap_tag;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   kred_multi_pipe_if #(.LOGC(LOGC), .LOGQH(4), .TAGW(4), .LOGT(12)) bus_a ();
   kred_multi_pipe_if #(.LOGC(LOGC), .LOGQH(4), .TAGW(4), .LOGT(14)) bus_b ();

   kred_multi_pipe #(.LOGQ(12), .LOGQH(4), .NRED(2), .CORRECT(1), .TAGW(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(bus_a), .busy(busy_a));
   kred_multi_pipe #(.LOGQ(12), .LOGQH(4), .NRED(1), .CORRECT(0), .TAGW(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(bus_b), .busy(busy_b));

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference: qH^2 * C mod q, straight modular arithmetic
   function automatic logic [11:0] model_a(input logic [23:0] c, input logic [3:0] qh);
      longint q, k;
      q = longint'(qh) * 256 + 1;
      k = (longint'(qh) * longint'(qh)) % q;
      return 12'((k * longint'(c)) % q);
   endfunction

   // Reference: one raw K-RED round, two's complement in 14 bits
   function automatic logic [13:0] model_b(input logic [23:0] c, input logic [3:0] qh);
      longint t;
      t = longint'(qh) * longint'(c % 256) - longint'(c / 256);
      return 14'(t);
   endfunction

   // Output monitor for dut_a: pop expected value on every output handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (bus_a.out_valid && bus_a.out_ready) begin
            out_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               fail("sb_unexpected_output");
            end else begin
               e = sb.pop_front();
               chk("sb_out_t", longint'(bus_a.out_t), longint'(e.t));
               chk("sb_out_tag", longint'(bus_a.out_tag), longint'(e.tag));
            end
         end
         if (flush_a) sb.delete();
      end
   end

   // Present one sample to dut_a; push its expectation when accepted
   task automatic send_a(input vec_t v);
      bit acc = 1'b0;
      int tries = 0;
      exp_t e;
      bus_a.in_valid = 1'b1;
      bus_a.in_c     = v.c;
      bus_a.in_qh    = v.qh;
      bus_a.in_tag   = v.tag;
      while (!acc && tries < 50) begin
         @(negedge clk);
         acc = bus_a.in_ready;
         if (acc) begin
            e.t   = v.exp;
            e.tag = v.tag;
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
         tries++;
      end
      bus_a.in_valid = 1'b0;
      if (!acc) fail("send_a_timeout");
   endtask

   task automatic send_lat_a(input vec_t v, input string name);
      int lat = 1;
      send_a(v);
      while (!bus_a.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, "_latency"}, lat, 3);
      chk({name, "_out_t"}, longint'(bus_a.out_t), longint'(v.exp));
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_a || busy_b) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy_a || busy_b) fail("idle_timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      vec_t v;
      logic [3:0] qsel [5];

      // Vector table
      vt[0] = '{c: 24'd1,        qh: 4'd13, tag: 4'd1, exp: 12'd169};
      vt[1] = '{c: 24'd11075584, qh: 4'd13, tag: 4'd2, exp: 12'd169};
      vt[2] = '{c: 24'd0,        qh: 4'd13, tag: 4'd3, exp: 12'd0};
      for (int i = 0; i < 8; i++) begin
         vt[3+i].c   = 24'd5;
         vt[3+i].qh  = (i % 2 == 0) ? 4'd13 : 4'd12;
         vt[3+i].tag = 4'(i);
         vt[3+i].exp = (i % 2 == 0) ? 12'd845 : 12'd720;
      end
      qsel[0] = 4'd13; qsel[1] = 4'd12; qsel[2] = 4'd15; qsel[3] = 4'd9; qsel[4] = 4'd14;
      for (int i = 0; i < 5; i++) begin
         longint q;
         q = longint'(qsel[i]) * 256 + 1;
         vt[11+i].qh  = qsel[i];
         vt[11+i].c   = 24'($urandom_range(0, 32'(q * q - 1)));
         vt[11+i].tag = 4'(8 + i);
         vt[11+i].exp = model_a(vt[11+i].c, vt[11+i].qh);
      end
      vb[0] = '{c: 24'd256, qh: 4'd13, exp: 14'h3FFF};
      vb[1] = '{c: 24'd0,       qh: 4'd13, exp: 14'd0};
      vb[2] = '{c: 24'd255,     qh: 4'd13, exp: 14'd0};
      vb[3] = '{c: 24'd65535,   qh: 4'd12, exp: 14'd0};
      vb[4] = '{c: 24'd1048575, qh: 4'd15, exp: 14'd0};
      for (int i = 2; i < 5; i++) vb[i].exp = model_b(vb[i].c, vb[i].qh);

      bus_a.in_valid = 1'b0; bus_a.in_c = '0; bus_a.in_qh = '0; bus_a.in_tag = '0;
      bus_a.out_ready = 1'b1;
      bus_b.in_valid = 1'b0; bus_b.in_c = '0; bus_b.in_qh = '0; bus_b.in_tag = '0;
      bus_b.out_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_out_valid_a", bus_a.out_valid, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_out_t_a", longint'(bus_a.out_t), 0);
      chk("rst_out_tag_a", longint'(bus_a.out_tag), 0);
      chk("rst_out_valid_b", bus_b.out_valid, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_in_ready_a", bus_a.in_ready, 1);

      // Single samples with latency
      send_lat_a(vt[0], "c1");
      wait_idle();
      send_lat_a(vt[1], "cmax");
      wait_idle();
      send_lat_a(vt[2], "c0");
      wait_idle();

      // Back-to-back alternating qH stream
      n0 = out_cyc.size();
      for (int i = 3; i < 11; i++) send_a(vt[i]);
      wait_idle();
      chk("alt_count", out_cyc.size() - n0, 8);
      if (out_cyc.size() >= n0 + 8)
         chk("alt_one_per_cycle", out_cyc[n0+7] - out_cyc[n0], 7);
      else
         fail("alt_one_per_cycle");

      // Random table vectors
      for (int i = 11; i < 16; i++) send_a(vt[i]);
      wait_idle();
      chk("rand_sb_empty", sb.size(), 0);

      // Stall for 5 cycles mid-stream
      n0 = out_cyc.size();
      fork
         begin
            for (int i = 3; i < 11; i++) send_a(vt[i]);
         end
         begin
            repeat (4) begin
               @(posedge clk);
               #1;
            end
            bus_a.out_ready = 1'b0;
            @(negedge clk);
            chk("stall_out_valid", bus_a.out_valid, 1);
            chk("stall_in_ready", bus_a.in_ready, 0);
            snap_t = bus_a.out_t;
            snap_tag = bus_a.out_tag;
            repeat (4) begin
               @(negedge clk);
               chk("stall_hold_valid", bus_a.out_valid, 1);
               chk("stall_hold_t", longint'(bus_a.out_t), longint'(snap_t));
               chk("stall_hold_tag", longint'(bus_a.out_tag), longint'(snap_tag));
               chk("stall_in_ready", bus_a.in_ready, 0);
            end
            @(posedge clk);
            #1;
            bus_a.out_ready = 1'b1;
         end
      join
      wait_idle();
      chk("stall_count", out_cyc.size() - n0, 8);
      chk("stall_sb_empty", sb.size(), 0);

      // Flush with three samples in flight
      v = '{c: 24'd7, qh: 4'd13, tag: 4'd1, exp: 12'd0};
      v.exp = model_a(v.c, v.qh);
      send_a(v);
      v = '{c: 24'd8, qh: 4'd13, tag: 4'd2, exp: 12'd0};
      v.exp = model_a(v.c, v.qh);
      send_a(v);
      v = '{c: 24'd9, qh: 4'd13, tag: 4'd3, exp: 12'd0};
      v.exp = model_a(v.c, v.qh);
      send_a(v);
      chk("flush_pre_busy", busy_a, 1);
      flush_a = 1'b1;
      bus_a.in_valid = 1'b1;
      bus_a.in_c = 24'd100;
      @(negedge clk);
      chk("flush_in_ready", bus_a.in_ready, 0);
      @(posedge clk);
      #1;
      flush_a = 1'b0;
      bus_a.in_valid = 1'b0;
      chk("flush_out_valid", bus_a.out_valid, 0);
      chk("flush_busy", busy_a, 0);
      n0 = out_cyc.size();
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("flush_no_output", out_cyc.size() - n0, 0);
      send_lat_a('{c: 24'd2, qh: 4'd13, tag: 4'd9, exp: 12'd338}, "post_flush");
      wait_idle();

      // Raw single-round instance
      for (int i = 0; i < 5; i++) begin
         bus_b.in_valid = 1'b1;
         bus_b.in_c     = vb[i].c;
         bus_b.in_qh    = vb[i].qh;
         bus_b.in_tag   = 4'(i);
         @(posedge clk);
         #1;
         chk("b_out_valid", bus_b.out_valid, 1);
         chk("b_out_t", longint'(bus_b.out_t), longint'(vb[i].exp));
         chk("b_out_tag", longint'(bus_b.out_tag), i);
      end
      bus_b.in_valid = 1'b0;
      wait_idle();

      // Asynchronous reset mid-stream
      bus_b.in_valid = 1'b1;
      bus_b.in_c = 24'd5;
      bus_b.in_qh = 4'd13;
      send_a(vt[3]);
      send_a(vt[4]);
      chk("rst_pre_busy_a", busy_a, 1);
      chk("rst_pre_valid_b", bus_b.out_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid_a", bus_a.out_valid, 0);
      chk("rst_async_busy_a", busy_a, 0);
      chk("rst_async_valid_b", bus_b.out_valid, 0);
      chk("rst_async_busy_b", busy_b, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus_b.in_valid = 1'b0;
      n0 = out_cyc.size();
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      chk("rst_no_output_a", out_cyc.size() - n0, 0);
      chk("rst_idle_valid_b", bus_b.out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
